// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if: CPU SRAM-style address and active-low strobe bundle
interface uart_tx_port_if;
    logic [15:0] addr;
    logic        memNotOE;
    logic        memNotWE;
    logic        memNotCS;
    modport master (output addr, memNotOE, memNotWE, memNotCS);
    modport slave  (input  addr, memNotOE, memNotWE, memNotCS);
endinterface

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 serial transmitter with a small write FIFO
module uart_tx_port #(
    parameter logic [15:0] BASE_ADDR    = 16'hFFF0,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic             clock,
    input  logic             reset,
    uart_tx_port_if.slave    bus,
    inout  wire  [15:0]      dataBus,
    output logic             txd,
    output logic             busy
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        last_q, last_d;
    logic              wr_prev_q, wr_prev_d;

    logic        sel, wr, wr_fire, rd_en, push, pop, accept, full, empty, bit_done;
    logic [1:0]  off;
    logic [15:0] rd_data;

    assign txd     = txd_q;
    assign busy    = (state_q != IDLE);
    assign dataBus = rd_en ? rd_data : 16'hzzzz;

    // Bus decode: select, one-shot write strobe and combinational read mux
    always_comb begin
        sel     = (bus.addr[15:2] == BASE_ADDR[15:2]) && !bus.memNotCS;
        off     = bus.addr[1:0];
        wr      = sel && !bus.memNotWE;
        wr_fire = wr && !wr_prev_q;
        rd_en   = sel && !bus.memNotOE && bus.memNotWE;
        push    = wr_fire && (off == 2'd0);
        full    = (count_q == CNTW'(FIFO_DEPTH));
        empty   = (count_q == '0);
        rd_data = (off == 2'd0) ? {8'h00, last_q} :
                  (off == 2'd1) ? {7'd0, 5'(count_q), ovf_q, busy, full, empty} : 16'h0000;
    end

    // FIFO, last-byte and sticky overflow; a pop on the same edge frees a full slot
    always_comb begin
        accept    = push && (!full || pop);
        mem_d     = mem_q;
        if (accept) mem_d[wr_ptr_q] = dataBus[7:0];
        wr_ptr_d  = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CNTW'(accept) - CNTW'(pop);
        last_d    = push ? dataBus[7:0] : last_q;
        ovf_d     = (push && !accept) ? 1'b1 :
                    (wr_fire && off == 2'd1 && dataBus[3]) ? 1'b0 : ovf_q;
        wr_prev_d = wr;
    end

    // Transmitter sequencing; txd is computed from the next state so it changes with the state
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        bit_done  = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: if (bit_done) begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                state_d   = DATA;
            end
            DATA: if (bit_done) begin
                clk_cnt_d = '0;
                shift_d   = {1'b0, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) state_d = STOP;
            end
            STOP: if (bit_done) begin
                clk_cnt_d = '0;
                pop       = !empty;
                state_d   = empty ? IDLE : START;
            end
        endcase
        if (pop) shift_d = mem_q[rd_ptr_q];
        txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end

    // State registers; reset aborts any frame and discards queued bytes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            mem_q     <= '{default: '0};
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            last_q    <= '0;
            wr_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            last_q    <= last_d;
            wr_prev_q <= wr_prev_d;
        end
    end
endmodule
